// File: rtl/sc_obstacle_scroll_pkg.sv
// Shared game definitions: FSM encodings and LFSR seed/tap constants.
package sc_obstacle_scroll_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CRASH = 2'd2
    } gameState_t;

    localparam int          NUM_ROWS  = 8;
    localparam logic [7:0]  LFSR_SEED = 8'hB8;
    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form, feedback enters at bit 0
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsrNext(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sc_lfsr8.sv
// Free-running 8-bit maximal-length LFSR; never stops, so start timing
// decides where obstacles spawn.
module sc_lfsr8
    import sc_obstacle_scroll_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] data
);

    // Step once per clock in every game state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) data <= LFSR_SEED;
        else       data <= lfsrNext(data);
    end

endmodule

// File: rtl/sc_obstacle_scroll.sv
// Obstacle road: 8-row scrolling buffer, tick divider and IDLE/RUN/CRASH FSM.
// Row 0 shares the player's row; obstacles enter at row 7 every other tick.
module sc_obstacle_scroll
    import sc_obstacle_scroll_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int TICK_DIV  = 12500000
) (
    input  logic                     SC_OBSTACLE_SCROLL_CLOCK_50,
    input  logic                     SC_OBSTACLE_SCROLL_RESET_InHigh,
    input  logic                     SC_OBSTACLE_SCROLL_start_InLow,
    input  logic [DATAWIDTH-1:0]     SC_OBSTACLE_SCROLL_player_InBUS,
    output logic [8*DATAWIDTH-1:0]   SC_OBSTACLE_SCROLL_rows_OutBUS,
    output logic                     SC_OBSTACLE_SCROLL_collision_OutLow,
    output logic [7:0]               SC_OBSTACLE_SCROLL_score_OutBUS
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic clk;
    logic rst;
    assign clk = SC_OBSTACLE_SCROLL_CLOCK_50;
    assign rst = SC_OBSTACLE_SCROLL_RESET_InHigh;

    gameState_t                              state;
    logic [NUM_ROWS-1:0][DATAWIDTH-1:0]      rows;
    logic [7:0]                              score;
    logic [CNT_W-1:0]                        tickCnt;
    logic                                    spawn;
    logic                                    startPrev;
    logic                                    collisionLow;
    logic [7:0]                              lfsrData;

    logic                 startEvt;
    logic                 tick;
    logic                 hit;
    logic [DATAWIDTH-1:0] newRow;
    logic                 unusedLfsrBits;

    sc_lfsr8 uLfsr (
        .clock (clk),
        .reset (rst),
        .data  (lfsrData)
    );

    // Only the low three bits pick a column; the rest just feed the sequence
    assign unusedLfsrBits = ^lfsrData[7:3];

    assign startEvt = !SC_OBSTACLE_SCROLL_start_InLow && startPrev;
    assign tick     = (state == RUN) && (tickCnt == TICK_LAST);
    assign hit      = (state == RUN) && |(rows[0] & SC_OBSTACLE_SCROLL_player_InBUS);
    // Spawn flag alternates, so an obstacle row is always followed by an empty one
    assign newRow   = spawn ? (DATAWIDTH'(1) << lfsrData[2:0]) : '0;

    // Game FSM, tick divider, row shifter and score; collision beats tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rows         <= '0;
            score        <= 8'd0;
            tickCnt      <= '0;
            spawn        <= 1'b0;
            startPrev    <= 1'b1;
            collisionLow <= 1'b1;
        end else begin
            startPrev <= SC_OBSTACLE_SCROLL_start_InLow;
            unique case (state)
                IDLE, CRASH: begin
                    tickCnt <= '0;
                    if (startEvt) begin
                        rows         <= '0;
                        score        <= 8'd0;
                        spawn        <= 1'b0;
                        collisionLow <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (hit) begin
                        state        <= CRASH;
                        collisionLow <= 1'b0;
                        tickCnt      <= '0;
                    end else if (tick) begin
                        tickCnt                <= '0;
                        rows[NUM_ROWS-2:0]     <= rows[NUM_ROWS-1:1];
                        rows[NUM_ROWS-1]       <= newRow;
                        spawn                  <= ~spawn;
                        if (rows[0] != '0 && score != 8'hFF)
                            score <= score + 8'd1;
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tickCnt <= '0;
                end
            endcase
        end
    end

    assign SC_OBSTACLE_SCROLL_rows_OutBUS      = rows;
    assign SC_OBSTACLE_SCROLL_score_OutBUS     = score;
    assign SC_OBSTACLE_SCROLL_collision_OutLow = collisionLow;

endmodule

// File: tb/tb_sc_obstacle_scroll.sv
// Scoreboard bench: driver steps a game-level model each cycle and queues the
// expected outputs; a monitor pops and compares after every rising edge.
module tb_sc_obstacle_scroll;

    localparam int DW = 8;
    localparam int TD = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            startN = 1'b1;
    logic [DW-1:0]   player = '0;
    logic [8*DW-1:0] rowsOut;
    logic            collN;
    logic [7:0]      scoreOut;

    always #5 clk = ~clk;

    sc_obstacle_scroll #(.DATAWIDTH(DW), .TICK_DIV(TD)) dut (
        .SC_OBSTACLE_SCROLL_CLOCK_50         (clk),
        .SC_OBSTACLE_SCROLL_RESET_InHigh     (rst),
        .SC_OBSTACLE_SCROLL_start_InLow      (startN),
        .SC_OBSTACLE_SCROLL_player_InBUS     (player),
        .SC_OBSTACLE_SCROLL_rows_OutBUS      (rowsOut),
        .SC_OBSTACLE_SCROLL_collision_OutLow (collN),
        .SC_OBSTACLE_SCROLL_score_OutBUS     (scoreOut)
    );

    typedef struct {
        logic [8*DW-1:0] rows;
        logic [7:0]      score;
        logic            coll;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    // Game model: 0 = idle, 1 = running, 2 = crashed. road[0] is the player row.
    int         mState;
    logic [7:0] road[$];
    int         mScore;
    int         runCycles;
    bit         mSpawn;
    logic [7:0] mLfsr;
    bit         mPrev;
    bit         mColl;

    function automatic void clearRoad();
        road = {};
        for (int k = 0; k < 8; k++) road.push_back(8'h00);
    endfunction

    function automatic void modelReset();
        mState = 0; clearRoad(); mScore = 0; runCycles = 0;
        mSpawn = 0; mLfsr = 8'hB8; mPrev = 1; mColl = 1;
    endfunction

    function automatic void modelStep(input bit s, input logic [7:0] p);
        bit         evt;
        logic [7:0] lf;
        logic [7:0] outRow;
        evt   = !s && mPrev;
        lf    = mLfsr;
        mPrev = s;
        mLfsr = {mLfsr[6:0], ^(mLfsr & 8'hB8)};
        if (mState != 1) begin
            if (evt) begin
                clearRoad(); mScore = 0; runCycles = 0; mSpawn = 0;
                mState = 1; mColl = 1;
            end
        end else if ((road[0] & p) != 0) begin
            mState = 2; mColl = 0;
        end else begin
            if (runCycles % TD == TD - 1) begin
                outRow = road.pop_front();
                if (outRow != 0 && mScore < 255) mScore++;
                road.push_back(mSpawn ? 8'(1 << lf[2:0]) : 8'h00);
                mSpawn = !mSpawn;
            end
            runCycles++;
        end
    endfunction

    function automatic exp_t snap();
        exp_t e;
        for (int k = 0; k < 8; k++) e.rows[k*DW +: DW] = road[k];
        e.score = 8'(mScore);
        e.coll  = mColl;
        return e;
    endfunction

    function automatic logic [7:0] dodge();
        return 8'($urandom) & ~road[0];
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic step(input bit s, input logic [7:0] p, input bit r);
        @(negedge clk);
        startN = s; player = p; rst = r;
        if (r) modelReset();
        else   modelStep(s, p);
        expQ.push_back(snap());
    endtask

    // Steer clear of obstacles until row 0 holds one (optionally on a tick
    // cycle), then steer into it.
    task automatic crashInto(input bit onTick, input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mState == 1 && road[0] != 0 &&
                (!onTick || runCycles % TD == TD - 1)) begin
                step(1, road[0], 0);
                found = 1;
            end else begin
                step(1, dodge(), 0);
            end
        end
        total++;
        if (!found || mState != 2) begin
            bad++;
            $display("FAIL %s got=%0d want=1 (crash setup)", name, found);
        end
    endtask

    // Compare each queued expectation shortly after the edge it belongs to
    always @(posedge clk) begin
        #2;
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            chk("rows", 64'(rowsOut), 64'(e.rows));
            chk("score", 64'(scoreOut), 64'(e.score));
            chk("collision", 64'(collN), 64'(e.coll));
        end
    end

    initial begin
        modelReset();
        repeat (3) step(1, 8'h00, 1);

        // idle with no start: road stays clear
        repeat (20) step(1, 8'($urandom), 0);

        // start press held a few cycles: exactly one start event
        step(0, 8'h01, 0);
        repeat (4) step(0, dodge(), 0);
        step(1, dodge(), 0);

        // run dodging; obstacles pass and score climbs
        repeat (300) step(1, dodge(), 0);

        // start pressed during RUN is ignored
        repeat (20) step(0, dodge(), 0);
        repeat (10) step(1, dodge(), 0);

        // collision coinciding with a tick, then frozen for 50 cycles
        crashInto(1, "crash_on_tick");
        repeat (50) step(1, 8'($urandom), 0);

        // start held low for 100 cycles in CRASH: one restart
        repeat (100) step(0, dodge(), 0);
        step(1, dodge(), 0);

        // long run to saturate the score
        repeat (2300) step(1, dodge(), 0);
        total++;
        if (mScore != 255) begin
            bad++;
            $display("FAIL saturate_setup got=%0d want=255", mScore);
        end
        crashInto(0, "crash_plain");
        repeat (20) step(1, 8'($urandom), 0);
        repeat (100) step(0, dodge(), 0);
        step(1, dodge(), 0);

        // reset in the middle of a run acts immediately
        repeat (30) step(1, dodge(), 0);
        @(negedge clk);
        #1 rst = 1;
        modelReset();
        expQ.push_back(snap());
        #1;
        chk("async_rows", 64'(rowsOut), 64'h0);
        chk("async_score", 64'(scoreOut), 64'h0);
        chk("async_collision", 64'(collN), 64'h1);
        step(1, 8'h00, 1);
        repeat (20) step(1, 8'($urandom), 0);

        @(posedge clk);
        #3;
        chk("queue_drained", 64'(expQ.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
